// File: rtl/shiftregister_pkg.sv
// Shared encodings for the universal shift register: operation modes and burst FSM states.
package shiftregister_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD        = 3'd0,
    MODE_SHIFT_UP    = 3'd1,
    MODE_SHIFT_DOWN  = 3'd2,
    MODE_ROTATE_UP   = 3'd3,
    MODE_ROTATE_DOWN = 3'd4,
    MODE_LOAD        = 3'd5
  } mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/shiftregister_nextstate.sv
// Combinational next-value function of the register for one operation.
module shiftregister_nextstate
  import shiftregister_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0]  out,
  input  logic [MODE_W-1:0] mode,
  input  logic              serialInputLow,
  input  logic              serialInputHigh,
  input  logic [WIDTH-1:0]  preset,
  output logic [WIDTH-1:0]  nextOut
);

  // Encodings 6 and 7 fall through to the default and behave as HOLD.
  always_comb begin
    nextOut = out;
    case (mode)
      MODE_SHIFT_UP:    nextOut = {out[WIDTH-2:0], serialInputLow};
      MODE_SHIFT_DOWN:  nextOut = {serialInputHigh, out[WIDTH-1:1]};
      MODE_ROTATE_UP:   nextOut = {out[WIDTH-2:0], out[WIDTH-1]};
      MODE_ROTATE_DOWN: nextOut = {out[0], out[WIDTH-1:1]};
      MODE_LOAD:        nextOut = preset;
      default:          nextOut = out;
    endcase
  end

endmodule

// File: rtl/shiftregister_universal.sv
// Universal shift register: free-running shift/rotate/load in IDLE, plus a counted
// burst started by a single pulse with busy/done handshake.
module shiftregister_universal
  import shiftregister_pkg::*;
#(
  parameter int WIDTH = 6,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic              clockpulse,
  input  logic              clear,
  input  logic [MODE_W-1:0] mode,
  input  logic              serialInputLow,
  input  logic              serialInputHigh,
  input  logic [WIDTH-1:0]  preset,
  input  logic              start,
  input  logic [CW-1:0]     shiftCount,
  output logic [WIDTH-1:0]  out,
  output logic [WIDTH-1:0]  notout,
  output logic              serialOutHigh,
  output logic              serialOutLow,
  output logic              busy,
  output logic              done
);

  state_t              state, stateNext;
  logic [CW-1:0]       count, countNext, satCount;
  logic [MODE_W-1:0]   burstMode, burstModeNext, opMode;
  logic [WIDTH-1:0]    outReg, outNext, shifted;
  logic                doneReg, doneNext;

  assign satCount = (shiftCount > CW'(WIDTH)) ? CW'(WIDTH) : shiftCount;

  // A burst runs on the mode latched at start; the live mode only drives IDLE.
  assign opMode = (state == ST_BURST) ? burstMode : mode;

  shiftregister_nextstate #(
    .WIDTH(WIDTH)
  ) u_nextstate (
    .out             (outReg),
    .mode            (opMode),
    .serialInputLow  (serialInputLow),
    .serialInputHigh (serialInputHigh),
    .preset          (preset),
    .nextOut         (shifted)
  );

  always_ff @(posedge clockpulse) begin
    if (clear) begin
      state     <= ST_IDLE;
      count     <= '0;
      burstMode <= MODE_HOLD;
      outReg    <= '0;
      doneReg   <= 1'b0;
    end else begin
      state     <= stateNext;
      count     <= countNext;
      burstMode <= burstModeNext;
      outReg    <= outNext;
      doneReg   <= doneNext;
    end
  end

  always_comb begin
    stateNext     = state;
    countNext     = count;
    burstModeNext = burstMode;
    outNext       = outReg;
    doneNext      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          burstModeNext = mode;
          countNext     = satCount;
          if (satCount == '0) begin
            doneNext = 1'b1;
          end else begin
            stateNext = ST_BURST;
          end
        end else begin
          outNext = shifted;
        end
      end
      ST_BURST: begin
        outNext   = shifted;
        countNext = count - CW'(1);
        if (count == CW'(1)) begin
          stateNext = ST_IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign out           = outReg;
  assign notout        = ~outReg;
  assign serialOutHigh = outReg[WIDTH-1];
  assign serialOutLow  = outReg[0];
  assign busy          = (state == ST_BURST);
  assign done          = doneReg;

endmodule

// File: tb/tb_shiftregister_universal.sv
// Self-checking bench: a 6-bit and an 8-bit instance compared against an arithmetic model.
module tb_shiftregister_universal;
  import shiftregister_pkg::*;

  logic clockpulse = 1'b0;
  always #5 clockpulse = ~clockpulse;

  logic       clear6, sil6, sih6, start6;
  logic [2:0] mode6;
  logic [5:0] preset6;
  logic [2:0] count6;
  logic [5:0] out6, notout6;
  logic       soh6, sol6, busy6, done6;

  logic       clear8, sil8, sih8, start8;
  logic [2:0] mode8;
  logic [7:0] preset8;
  logic [3:0] count8;
  logic [7:0] out8, notout8;
  logic       soh8, sol8, busy8, done8;

  shiftregister_universal #(.WIDTH(6)) dut6 (
    .clockpulse(clockpulse), .clear(clear6), .mode(mode6),
    .serialInputLow(sil6), .serialInputHigh(sih6), .preset(preset6),
    .start(start6), .shiftCount(count6), .out(out6), .notout(notout6),
    .serialOutHigh(soh6), .serialOutLow(sol6), .busy(busy6), .done(done6));

  shiftregister_universal #(.WIDTH(8)) dut8 (
    .clockpulse(clockpulse), .clear(clear8), .mode(mode8),
    .serialInputLow(sil8), .serialInputHigh(sih8), .preset(preset8),
    .start(start8), .shiftCount(count8), .out(out8), .notout(notout8),
    .serialOutHigh(soh8), .serialOutLow(sol8), .busy(busy8), .done(done8));

  int compared = 0;
  int mismatched = 0;

  // Reference model: register value as a number, burst as "cycles remaining".
  logic [7:0] m6Out, m8Out;
  int         m6Left, m8Left;
  logic [2:0] m6Mode, m8Mode;
  logic       m6Done, m8Done;

  function automatic logic [7:0] applyOp(int w, logic [2:0] md, logic [7:0] v,
                                         logic sl, logic sh, logic [7:0] p);
    logic [7:0] mask;
    mask = 8'((1 << w) - 1);
    case (md)
      3'd1:    return ((v << 1) | 8'(sl)) & mask;
      3'd2:    return (v >> 1) | (8'(sh) << (w - 1));
      3'd3:    return ((v << 1) | (v >> (w - 1))) & mask;
      3'd4:    return (v >> 1) | ((v & 8'd1) << (w - 1));
      3'd5:    return p & mask;
      default: return v;
    endcase
  endfunction

  task automatic modelStep(input int w, input logic cl, input logic st, input logic sl,
                           input logic sh, input logic [2:0] md, input logic [7:0] p,
                           input int cnt, inout logic [7:0] mo, inout int left,
                           inout logic [2:0] mm, inout logic dn);
    if (cl) begin
      mo = 8'd0; left = 0; dn = 1'b0;
    end else if (left > 0) begin
      mo = applyOp(w, mm, mo, sl, sh, p);
      left = left - 1;
      dn = (left == 0);
    end else if (st) begin
      mm = md;
      left = (cnt > w) ? w : cnt;
      dn = (left == 0);
    end else begin
      mo = applyOp(w, md, mo, sl, sh, p);
      dn = 1'b0;
    end
  endtask

  function automatic logic [15:0] exp6();
    return {m6Out[5:0], ~m6Out[5:0], m6Out[5], m6Out[0], m6Left > 0, m6Done};
  endfunction

  function automatic logic [19:0] exp8();
    return {m8Out, ~m8Out, m8Out[7], m8Out[0], m8Left > 0, m8Done};
  endfunction

  logic [15:0] obs6;
  logic [19:0] obs8;
  assign obs6 = {out6, notout6, soh6, sol6, busy6, done6};
  assign obs8 = {out8, notout8, soh8, sol8, busy8, done8};

  task automatic tick();
    modelStep(6, clear6, start6, sil6, sih6, mode6, 8'(preset6), int'(count6),
              m6Out, m6Left, m6Mode, m6Done);
    modelStep(8, clear8, start8, sil8, sih8, mode8, preset8, int'(count8),
              m8Out, m8Left, m8Mode, m8Done);
    @(posedge clockpulse);
    #1;
  endtask

  task automatic quiet();
    clear6 = 0; start6 = 0; mode6 = MODE_HOLD; sil6 = 0; sih6 = 0; preset6 = '0; count6 = '0;
    clear8 = 0; start8 = 0; mode8 = MODE_HOLD; sil8 = 0; sih8 = 0; preset8 = '0; count8 = '0;
  endtask

  task automatic test_reset();
    quiet();
    mode6 = 3'($urandom); preset6 = 6'($urandom); start6 = 1'b1; sil6 = 1'b1;
    mode8 = 3'($urandom); preset8 = 8'($urandom); start8 = 1'b1;
    clear6 = 1'b1; clear8 = 1'b1;
    tick();
    compared++;
    if (obs6 !== 16'b000000_111111_0_0_0_0) begin
      mismatched++; $display("FAIL reset6: got %h required %h", obs6, 16'b000000_111111_0_0_0_0);
    end
    compared++;
    if (obs8 !== exp8()) begin
      mismatched++; $display("FAIL reset8: got %h required %h", obs8, exp8());
    end
    quiet();
  endtask

  task automatic test_load_shift();
    logic [5:0] want [3];
    want[0] = 6'b101101; want[1] = 6'b011011; want[2] = 6'b110111;
    quiet();
    mode6 = MODE_LOAD; preset6 = 6'b101101;
    tick();
    mode6 = MODE_SHIFT_UP; sil6 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      compared++;
      if (out6 !== want[i] || obs6 !== exp6()) begin
        mismatched++; $display("FAIL load_shift step %0d: got %h required out %b model %h", i, obs6, want[i], exp6());
      end
    end
    compared++;
    if (soh6 !== 1'b1) begin
      mismatched++; $display("FAIL load_shift serialOutHigh: got %b required 1", soh6);
    end
    quiet();
  endtask

  task automatic test_burst_rotate();
    logic [5:0] want [3];
    want[0] = 6'b110000; want[1] = 6'b011000; want[2] = 6'b001100;
    quiet();
    mode6 = MODE_LOAD; preset6 = 6'b100001;
    tick();
    mode6 = MODE_ROTATE_DOWN; start6 = 1'b1; count6 = 3'd3;
    tick();
    compared++;
    if (obs6 !== exp6() || busy6 !== 1'b1 || out6 !== 6'b100001) begin
      mismatched++; $display("FAIL burst_rotate start: got %h required %h", obs6, exp6());
    end
    start6 = 1'b0; mode6 = MODE_HOLD;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (out6 !== want[i] || busy6 !== (i < 2) || done6 !== (i == 2) || obs6 !== exp6()) begin
        mismatched++; $display("FAIL burst_rotate cycle %0d: got %h required out %b model %h", i, obs6, want[i], exp6());
      end
    end
    tick();
    compared++;
    if (obs6 !== exp6() || done6 !== 1'b0) begin
      mismatched++; $display("FAIL burst_rotate after: got %h required %h", obs6, exp6());
    end
  endtask

  task automatic test_zero_and_ignored_start();
    int doneCount;
    logic [5:0] held;
    quiet();
    held = out6;
    start6 = 1'b1; count6 = 3'd0; mode6 = MODE_SHIFT_UP;
    tick();
    start6 = 1'b0; mode6 = MODE_HOLD;
    compared++;
    if (done6 !== 1'b1 || busy6 !== 1'b0 || out6 !== held || obs6 !== exp6()) begin
      mismatched++; $display("FAIL zero_count pulse: got %h required %h", obs6, exp6());
    end
    tick();
    compared++;
    if (done6 !== 1'b0 || obs6 !== exp6()) begin
      mismatched++; $display("FAIL zero_count single: got %h required %h", obs6, exp6());
    end
    start6 = 1'b1; count6 = 3'd5; mode6 = MODE_SHIFT_UP; sil6 = 1'b1;
    tick();
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      start6 = (i == 1 || i == 3); count6 = 3'd2; sil6 = 1'($urandom);
      tick();
      if (done6) doneCount++;
      compared++;
      if (obs6 !== exp6()) begin
        mismatched++; $display("FAIL ignored_start cycle %0d: got %h required %h", i, obs6, exp6());
      end
    end
    compared++;
    if (doneCount !== 1) begin
      mismatched++; $display("FAIL ignored_start done count: got %0d required 1", doneCount);
    end
    quiet();
  endtask

  task automatic test_saturate();
    int busyCycles;
    quiet();
    start6 = 1'b1; count6 = 3'd7; mode6 = MODE_ROTATE_UP;
    tick();
    quiet();
    busyCycles = 0;
    for (int i = 0; i < 10 && busy6; i++) begin
      busyCycles++;
      tick();
      compared++;
      if (obs6 !== exp6()) begin
        mismatched++; $display("FAIL saturate cycle %0d: got %h required %h", i, obs6, exp6());
      end
    end
    compared++;
    if (busyCycles !== 6 || done6 !== 1'b1) begin
      mismatched++; $display("FAIL saturate length: got %0d done %b required 6 done 1", busyCycles, done6);
    end
  endtask

  task automatic test_clear_midburst();
    quiet();
    mode6 = MODE_LOAD; preset6 = 6'b111011;
    tick();
    mode6 = MODE_SHIFT_DOWN; start6 = 1'b1; count6 = 3'd4;
    tick();
    start6 = 1'b0; mode6 = MODE_HOLD; sih6 = 1'b1;
    tick();
    clear6 = 1'b1;
    tick();
    clear6 = 1'b0;
    compared++;
    if (out6 !== 6'd0 || busy6 !== 1'b0 || done6 !== 1'b0 || obs6 !== exp6()) begin
      mismatched++; $display("FAIL clear_midburst: got %h required %h", obs6, exp6());
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if (done6 !== 1'b0 || obs6 !== exp6()) begin
        mismatched++; $display("FAIL clear_midburst quiet %0d: got %h required %h", i, obs6, exp6());
      end
    end
    mode6 = MODE_SHIFT_DOWN; start6 = 1'b1; count6 = 3'd2;
    tick();
    start6 = 1'b0; mode6 = MODE_HOLD;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (obs6 !== exp6()) begin
        mismatched++; $display("FAIL clear_midburst restart %0d: got %h required %h", i, obs6, exp6());
      end
    end
  endtask

  task automatic test_rotate8();
    quiet();
    mode8 = MODE_LOAD; preset8 = 8'hA5;
    tick();
    mode8 = MODE_ROTATE_UP; start8 = 1'b1; count8 = 4'd8;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) mode8 = MODE_SHIFT_DOWN;
      tick();
      compared++;
      if (obs8 !== exp8()) begin
        mismatched++; $display("FAIL rotate8 cycle %0d: got %h required %h", i, obs8, exp8());
      end
    end
    compared++;
    if (out8 !== 8'hA5 || done8 !== 1'b1 || busy8 !== 1'b0) begin
      mismatched++; $display("FAIL rotate8 final: got out %h done %b busy %b required a5 1 0", out8, done8, busy8);
    end
    quiet();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear6 = ($urandom_range(0, 29) == 0); clear8 = ($urandom_range(0, 29) == 0);
      start6 = ($urandom_range(0, 5) == 0);  start8 = ($urandom_range(0, 5) == 0);
      mode6 = 3'($urandom); mode8 = 3'($urandom);
      sil6 = 1'($urandom); sih6 = 1'($urandom); sil8 = 1'($urandom); sih8 = 1'($urandom);
      preset6 = 6'($urandom); preset8 = 8'($urandom);
      count6 = 3'($urandom); count8 = 4'($urandom_range(0, 10));
      tick();
      compared++;
      if (obs6 !== exp6()) begin
        mismatched++; $display("FAIL random6 cycle %0d: got %h required %h", i, obs6, exp6());
      end
      compared++;
      if (obs8 !== exp8()) begin
        mismatched++; $display("FAIL random8 cycle %0d: got %h required %h", i, obs8, exp8());
      end
    end
    quiet();
  endtask

  initial begin
    m6Out = '0; m8Out = '0; m6Left = 0; m8Left = 0;
    m6Mode = '0; m8Mode = '0; m6Done = 0; m8Done = 0;
    quiet();
    #2;
    test_reset();
    test_load_shift();
    test_burst_rotate();
    test_zero_and_ignored_start();
    test_saturate();
    test_clear_midburst();
    test_rotate8();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
